fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 16x9 simultaneous-read/write FIFO among N producers.
- Grants one producer at a time for a bounded burst.
- Generates the FIFO's active-low write strobe and data.
- Never issues a write while the FIFO reports Full, so the FIFO's overflow path is never exercised by arbitrated traffic.

Parameters:
- N, 2: number of requesters (2..8).
- WIDTH, 9: data width; matches FIFO DataIn.
- BURST, 4: maximum words written per grant (1..16).

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  N  per-requester write request; bit i belongs to requester i.
- DataIn  in  N*WIDTH  requester i data on [WIDTH*i+WIDTH-1 : WIDTH*i].
- Ack  out  N  one-hot; Ack[i]=1 means the word on requester i's DataIn is written at this edge.
- Grant  out  N  one-hot registered owner of the write port; 0 when idle.
- FifoData  out  WIDTH  to FIFO DataIn.
- FifoWrite_n  out  1  to FIFO Write; active-low, one word per low cycle.
- FifoFull  in  1  from FIFO Full.
- Busy  out  1  1 whenever the state is BURST.

Behaviour:
- States: IDLE and BURST. Registers: state, Grant, winner index w, last-winner pointer LastW, burst counter Cnt (width ceil(log2(BURST+1))).
- Reset values (Reset=1 at an edge): state=IDLE, Grant=0, Cnt=0, LastW=N-1, so requester 0 wins first. Combinational outputs while Reset=1: Ack=0, FifoWrite_n=1, FifoData=0, Busy=0, so no write lands in the reset cycle.
- IDLE:
  - If any Req bit is set, the winner is the first set bit searching from (LastW+1) mod N upward with wrap.
  - At the next edge: state=BURST, w=winner, Grant=onehot(winner), Cnt=0.
  - Latency from Req rising to Grant is 1 cycle.
- BURST:
  - Write condition WE = Req[w] & ~FifoFull & (Cnt<BURST).
  - Combinational outputs: FifoWrite_n=~WE; Ack[w]=WE, other Ack bits 0; FifoData=DataIn[w] while in BURST, else 0.
  - The FIFO samples at the same edge, so there is zero added data latency.
  - On each WE edge: Cnt=Cnt+1.
- Requester rule: in any cycle with Ack[i]=1, requester i must present its next word or drop Req[i] before the next edge.
- Leaving BURST: at the edge where (WE & Cnt==BURST-1) or ~Req[w], the block goes to IDLE with Grant=0, LastW=w, Cnt=0. There is exactly one idle cycle between consecutive grants.
- FifoFull=1 in BURST: no write, no Ack; Grant, Cnt and state are held. The burst resumes when Full drops. Grant is not revoked while Req[w] stays high.
- Req[w] dropping while stalled on Full: the block releases to IDLE at that edge.
- Reset mid-burst: the burst is abandoned. The in-flight word is not written, because WE is gated in the reset cycle.
- A Req change on a non-granted requester has no effect until the next IDLE.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - Adds output WordCount (N*8 bits).
  - Per requester, an 8-bit saturating count of accepted words (Ack edges); holds at 255.
  - Cleared by Reset.
- Undefined: no WordCount port, no counters; all other behaviour is identical.

Test Plan:
- Reset check: drive Reset=1 with Req=2'b11 for 2 cycles. Required: Grant=0, Ack=0, FifoWrite_n=1, FifoData=0, Busy=0. After release, the first Grant is 2'b01.
- Single requester (N=2, BURST=4), Full=0: requester 0 holds Req with words 0x101..0x106. Required:
  - Grant=01 one cycle after Req.
  - FifoWrite_n low 4 consecutive cycles with 0x101..0x104.
  - One idle cycle, then Grant=01 again.
  - 0x105, 0x106 written; release on Req drop.
- Contention: both requesters hold Req continuously. Required: grants alternate 01,10,01,10, each with 4 writes, separated by exactly one Grant=0 cycle.
- Full stall: FifoFull=1 for 3 cycles after the 2nd write of a burst. Required: FifoWrite_n=1 and Ack=0 for those 3 cycles; Grant held; then exactly 2 more writes, then release.
- Early drop: requester 1 drops Req after 1 accepted word while requester 0 is requesting. Required: Grant=0 at the next edge, LastW=1, then Grant=01.
- Stats (FIFO_ARB_STATS_EN): requester 0 writes 300 words. Required: WordCount[7:0] saturates at 255; requester 1's count is unaffected.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter for the shared FIFO write port
// Optional: FIFO_ARB_STATS_EN adds per-requester saturating WordCount outputs.
module fifo_write_arbiter #(
    parameter int N     = 2,
    parameter int WIDTH = 9,
    parameter int BURST = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [N-1:0]         Req,
    input  logic [N*WIDTH-1:0]   DataIn,
    output logic [N-1:0]         Ack,
    output logic [N-1:0]         Grant,
    output logic [WIDTH-1:0]     FifoData,
    output logic                 FifoWrite_n,
    input  logic                 FifoFull,
    output logic                 Busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N*8-1:0]       WordCount
`endif
);

    localparam int IdxW = (N > 1) ? $clog2(N) : 1;
    localparam int CntW = $clog2(BURST + 1);

    localparam logic IDLE  = 1'b0;
    localparam logic BURST_ST = 1'b1;

    logic            state;
    logic [IdxW-1:0] w;
    logic [IdxW-1:0] lastW;
    logic [CntW-1:0] Cnt;
    logic [IdxW-1:0] winner;
    logic            inBurst;
    logic            we;

    // Rotating priority: first set request strictly after the previous winner.
    always_comb begin
        int s;
        logic found;
        logic [IdxW-1:0] cand;
        winner = '0;
        found  = 1'b0;
        s      = 0;
        cand   = '0;
        for (int k = 1; k <= N; k++) begin
            s = int'(lastW) + k;
            if (s >= N) s = s - N;
            cand = IdxW'(s);
            if (!found && Req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Outputs are gated by Reset so nothing reaches the FIFO during a reset cycle.
    assign inBurst     = (state == BURST_ST) && !Reset;
    assign we          = inBurst && Req[w] && !FifoFull && (Cnt < CntW'(BURST));
    assign FifoWrite_n = ~we;
    assign Busy        = inBurst;
    assign FifoData    = inBurst ? DataIn[w*WIDTH +: WIDTH] : '0;

    always_comb begin
        Ack    = '0;
        Ack[w] = we;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            Grant <= '0;
            Cnt   <= '0;
            lastW <= IdxW'(N - 1);
            w     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|Req) begin
                        state <= BURST_ST;
                        w     <= winner;
                        Grant <= {{(N-1){1'b0}}, 1'b1} << winner;
                        Cnt   <= '0;
                    end
                end
                BURST_ST: begin
                    if ((we && Cnt == CntW'(BURST - 1)) || !Req[w]) begin
                        state <= IDLE;
                        Grant <= '0;
                        lastW <= w;
                        Cnt   <= '0;
                    end else if (we) begin
                        Cnt <= Cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar i = 0; i < N; i++) begin : g_stats
        logic [7:0] words;
        always_ff @(posedge Clock) begin
            if (Reset) begin
                words <= '0;
            end else if (Ack[i] && words != 8'hFF) begin
                words <= words + 8'd1;
            end
        end
        assign WordCount[i*8 +: 8] = words;
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - randomized scoreboard bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

    localparam int N     = 2;
    localparam int WIDTH = 9;
    localparam int BURST = 4;

    logic                 Clock = 1'b0;
    logic                 Reset;
    logic [N-1:0]         Req;
    logic [N*WIDTH-1:0]   DataIn;
    logic [N-1:0]         Ack;
    logic [N-1:0]         Grant;
    logic [WIDTH-1:0]     FifoData;
    logic                 FifoWrite_n;
    logic                 FifoFull;
    logic                 Busy;
`ifdef FIFO_ARB_STATS_EN
    logic [N*8-1:0]       WordCount;
`endif

    fifo_write_arbiter #(.N(N), .WIDTH(WIDTH), .BURST(BURST)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .DataIn(DataIn),
        .Ack(Ack), .Grant(Grant), .FifoData(FifoData),
        .FifoWrite_n(FifoWrite_n), .FifoFull(FifoFull), .Busy(Busy)
`ifdef FIFO_ARB_STATS_EN
        , .WordCount(WordCount)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [N-1:0]     grant;
        logic             wn;
        logic [N-1:0]     ack;
        logic [WIDTH-1:0] data;
        logic             busy;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: owner index (-1 when idle), words written this grant, previous owner.
    int owner = -1;
    int used  = 0;
    int prev  = N - 1;
    logic [WIDTH-1:0] word [N];
    int stats [N];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            chk("grant", int'(Grant), int'(e.grant));
            chk("write_n", int'(FifoWrite_n), int'(e.wn));
            chk("ack", int'(Ack), int'(e.ack));
            chk("fifo_data", int'(FifoData), int'(e.data));
            chk("busy", int'(Busy), int'(e.busy));
        end
    end

    task automatic step(input logic rst, input logic [N-1:0] req, input logic full);
        exp_t e;
        logic wr;
        @(posedge Clock);
        #1;
        Reset    = rst;
        Req      = req;
        FifoFull = full;
        for (int i = 0; i < N; i++) DataIn[i*WIDTH +: WIDTH] = word[i];

        e.grant = (owner >= 0) ? (N'(1) << owner) : '0;
        e.ack   = '0;
        e.wn    = 1'b1;
        e.data  = '0;
        e.busy  = 1'b0;
        wr      = 1'b0;
        if (!rst && owner >= 0) begin
            e.busy = 1'b1;
            e.data = word[owner];
            wr     = req[owner] && !full && (used < BURST);
            e.wn   = ~wr;
            if (wr) e.ack = N'(1) << owner;
        end
        expQ.push_back(e);

        if (rst) begin
            owner = -1;
            used  = 0;
            prev  = N - 1;
            for (int i = 0; i < N; i++) stats[i] = 0;
        end else if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (owner < 0 && req[(prev + k) % N]) owner = (prev + k) % N;
            end
            used = 0;
        end else begin
            if (wr) begin
                if (stats[owner] < 255) stats[owner]++;
                word[owner] = WIDTH'($urandom);
                used++;
            end
            if ((wr && used == BURST) || !req[owner]) begin
                prev  = owner;
                owner = -1;
                used  = 0;
            end
        end
    endtask

    initial begin
        logic [N-1:0] r;
        Reset    = 1'b1;
        Req      = '0;
        FifoFull = 1'b0;
        for (int i = 0; i < N; i++) begin
            word[i]  = WIDTH'($urandom);
            stats[i] = 0;
        end
        DataIn = '0;
        @(posedge Clock);

        // Reset held with both requesting, then requester 0 must win first.
        step(1'b1, 2'b11, 1'b0);
        step(1'b1, 2'b11, 1'b0);
        for (int c = 0; c < 20; c++) step(1'b0, 2'b01, 1'b0);
        for (int c = 0; c < 40; c++) step(1'b0, 2'b11, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b0);

        // Single-requester bursts with a Full stall after the second write.
        step(1'b0, 2'b01, 1'b0);
        step(1'b0, 2'b01, 1'b0);
        step(1'b0, 2'b01, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, 2'b01, 1'b1);
        for (int c = 0; c < 4; c++) step(1'b0, 2'b01, 1'b0);

        // Requester 1 drops after one word while requester 0 waits.
        step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b10, 1'b0);
        step(1'b0, 2'b11, 1'b0);
        step(1'b0, 2'b01, 1'b0);
        for (int c = 0; c < 6; c++) step(1'b0, 2'b01, 1'b0);

        r = 2'b11;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
            step(($urandom_range(0, 99) == 0), r, ($urandom_range(0, 3) == 0));
        end

`ifdef FIFO_ARB_STATS_EN
        step(1'b1, 2'b00, 1'b0);
        for (int c = 0; c < 420; c++) step(1'b0, 2'b01, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        @(negedge Clock);
        for (int i = 0; i < N; i++) chk("word_count", int'(WordCount[i*8 +: 8]), stats[i]);
        chk("word_count_sat", int'(WordCount[7:0]), 255);
`endif

        step(1'b0, 2'b00, 1'b0);
        @(negedge Clock);
        #1;
        chk("queue_drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
